mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the execute stage and write-back. It registers the execute-to-memory bus and aligns and extends synchronous data-SRAM read data for all load types. It drives forwarding and write-back buses and raises a write-disable to the execute stage while an exception or ERET is pending in this stage. The SRAM returns read data exactly one cycle after the execute stage issues the request, so the stage never stalls on memory.

## Interface
Parameters: none; all widths come from the shared CPU definitions package.
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ws_allowin  in  1  write-back can accept this cycle
- ms_allowin  out  1  this stage can accept this cycle
- es_to_ms_bus  in  es_to_ms_bus_t  from execute; fields: valid, load_op, c0_op, c0_addr, res_from_mem, rf_we, dest, final_result, pc, exception
- data_sram_rdata  in  32  read data for the request issued by execute in the previous cycle
- ms_to_ws_bus  out  ms_to_ws_bus_t  to write-back; fields: valid, c0_op, c0_addr, rf_wstrb[3:0], dest, result, pc, exception
- ms_forward_bus  out  ms_forward_bus_t  fields: op_mfc0, dest, rf_wstrb, result
- ms_wr_disable  out  1  to execute: suppress stores and HI/LO writes
- pipeline_flush  in  pipeline_flush_t  fields: ex, eret

## Operation
- Pipeline register:
  - ms_valid loads es_to_ms_bus.valid when ms_allowin is high.
  - The bus register loads only when es_to_ms_bus.valid && ms_allowin.
- ms_ready_go = ms_valid. ms_allowin = !ms_valid || ws_allowin. ms_to_ws valid = ms_valid.
- Flush: pipeline_flush.ex or pipeline_flush.eret clears ms_valid on the next edge and takes priority over loading. Reset takes priority over flush.
- Address: a = final_result[1:0], the low bits of the ALU address. Misaligned LH, LHU and LW are trapped upstream, so this stage ignores a[0] for halfwords.
- load_op is a one-hot 7-bit vector. Bit assignments LW, LB, LBU, LH, LHU, LWL, LWR are fixed in the package.
- Load result per load type (r = data_sram_rdata):
  - LW: r.
  - LB / LBU: byte a, sign- or zero-extended.
  - LH / LHU: halfword a[1], sign- or zero-extended.
  - LWL: r << 8*(3-a); rf_wstrb = 4'b1111 << (3-a), truncated to 4 bits.
  - LWR: r >> 8*a; rf_wstrb = 4'b1111 >> a.
  - All other loads: rf_wstrb = {4{rf_we}}.
- result = res_from_mem ? load result : final_result.
- Exception carried in from execute (exception.ex = 1): rf_wstrb forced to 0; the exception record passes through unchanged.
- rf_wstrb is also 0 whenever ms_valid = 0.
- Forwarding:
  - op_mfc0 = c0_op[2] & ms_valid.
  - dest = dest & {5{ms_valid}}.
  - result is the aligned load result, so consumers never stall on a load in this stage.
- ms_wr_disable = ms_valid & (exception.ex | c0_op[0]), where c0_op[0] = ERET.

## Timing
- Reset: ms_valid = 0, ms_to_ws_bus.valid = 0, rf_wstrb = 0, forward dest = 0, op_mfc0 = 0, ms_wr_disable = 0. Other bus fields are don't-care.
- Latency: one cycle, from execute handshake to a valid ms_to_ws_bus.
- data_sram_rdata is valid only in the first cycle the instruction sits in this stage. If ws_allowin is low in that cycle, the stage holds the aligned result in a 32-bit hold register and uses it until the handoff.
- The hold register captures on the first valid cycle of each instruction. That cycle is tracked by a first-cycle flag, set on load and cleared after one cycle.
- Flush in the same cycle as an incoming valid: incoming instruction dropped, ms_valid = 0.
- Back-to-back loads at full rate: no bubbles.

## Structure
- Package (cpu_defs): es_to_ms_bus_t, ms_to_ws_bus_t, ms_forward_bus_t, pipeline_flush_t, exception_t, load_op bit indices, c0_op bit meanings.
- Sub-module load_align: combinational block.
  - Inputs: load_op, a, r.
  - Outputs: aligned data, rf_wstrb.
- Top level holds the valid register, bus register, first-cycle flag, hold register, and output muxing.

## Test plan
- LB at address ...3, rdata 0x80FF_1234 -> result 0xFFFF_FF80, rf_wstrb 1111. The same case as LBU -> result 0x0000_0080.
- LWL with a=1, rdata 0xAABB_CCDD -> result 0xCCDD_0000, rf_wstrb 1100. LWR with a=2 -> result 0x0000_AABB, rf_wstrb 0011.
- Load with ws_allowin low for 3 cycles, rdata changed to garbage after the first cycle -> the original aligned value is handed off when ws_allowin rises; ms_allowin stays low during the stall.
- Incoming exception.ex = 1 (AdEL) on LW -> rf_wstrb 0, ms_wr_disable 1 while valid, badvaddr passed through.
- pipeline_flush.ex asserted while a valid instruction sits in the stage and a new one arrives -> next cycle ms_valid 0, forward dest 0.
- reset asserted mid-stream -> all outputs at reset values on the next edge; the first instruction after reset is handled normally.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared CPU definitions for the MIPS pipeline.
// Defines the inter-stage bus records, the exception record, the pipeline
// flush record, the one-hot load_op bit indices and the c0_op bit meanings.
package cpu_defs;

    // load_op one-hot bit indices
    localparam int LOAD_LW  = 0;
    localparam int LOAD_LB  = 1;
    localparam int LOAD_LBU = 2;
    localparam int LOAD_LH  = 3;
    localparam int LOAD_LHU = 4;
    localparam int LOAD_LWL = 5;
    localparam int LOAD_LWR = 6;

    // c0_op bit meanings
    localparam int C0_ERET = 0;
    localparam int C0_MTC0 = 1;
    localparam int C0_MFC0 = 2;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic        bd;
        logic [31:0] badvaddr;
    } exception_t;

    typedef struct packed {
        logic        valid;
        logic [6:0]  load_op;
        logic [2:0]  c0_op;
        logic [7:0]  c0_addr;
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
        exception_t  exception;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  c0_op;
        logic [7:0]  c0_addr;
        logic [3:0]  rf_wstrb;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        exception_t  exception;
    } ms_to_ws_bus_t;

    typedef struct packed {
        logic        op_mfc0;
        logic [4:0]  dest;
        logic [3:0]  rf_wstrb;
        logic [31:0] result;
    } ms_forward_bus_t;

    typedef struct packed {
        logic ex;
        logic eret;
    } pipeline_flush_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational load data alignment and extension.
// Ports:
//   load_op_i  one-hot load type (bit indices from cpu_defs)
//   a_i        low two address bits
//   r_i        raw SRAM read word
//   data_o     aligned / extended load data
//   wstrb_o    byte write strobe for LWL/LWR; all ones for other loads
module load_align
    import cpu_defs::*;
(
    input  logic [6:0]  load_op_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] r_i,
    output logic [31:0] data_o,
    output logic [3:0]  wstrb_o
);

    logic [31:0] byte_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [1:0]  lwl_sh;

    assign byte_word = r_i >> {a_i, 3'b000};
    assign byte_sel  = byte_word[7:0];
    // Halfword loads are aligned upstream, so only a[1] picks the half.
    assign half_sel  = a_i[1] ? r_i[31:16] : r_i[15:0];
    assign lwl_sh    = 2'd3 - a_i;

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        data_o  = r_i;
        wstrb_o = 4'b1111;
        if (load_op_i[LOAD_LB]) begin
            data_o = {{24{byte_sel[7]}}, byte_sel};
        end else if (load_op_i[LOAD_LBU]) begin
            data_o = {24'h0, byte_sel};
        end else if (load_op_i[LOAD_LH]) begin
            data_o = {{16{half_sel[15]}}, half_sel};
        end else if (load_op_i[LOAD_LHU]) begin
            data_o = {16'h0, half_sel};
        end else if (load_op_i[LOAD_LWL]) begin
            data_o  = r_i << {lwl_sh, 3'b000};
            wstrb_o = 4'b1111 << lwl_sh;
        end else if (load_op_i[LOAD_LWR]) begin
            data_o  = r_i >> {a_i, 3'b000};
            wstrb_o = 4'b1111 >> a_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline.
// Registers the execute-to-memory bus, aligns synchronous SRAM read data,
// and drives the write-back and forwarding buses.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ws_allowin        write-back can accept this cycle
//   ms_allowin        this stage can accept this cycle
//   es_to_ms_bus      instruction from execute
//   data_sram_rdata   read data for the request issued last cycle
//   ms_to_ws_bus      instruction to write-back
//   ms_forward_bus    forwarding info to decode
//   ms_wr_disable     exception/ERET pending: execute suppresses side effects
//   pipeline_flush    exception / ERET flush
module mem_stage
    import cpu_defs::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ws_allowin,
    output logic            ms_allowin,
    input  es_to_ms_bus_t   es_to_ms_bus,
    input  logic [31:0]     data_sram_rdata,
    output ms_to_ws_bus_t   ms_to_ws_bus,
    output ms_forward_bus_t ms_forward_bus,
    output logic            ms_wr_disable,
    input  pipeline_flush_t pipeline_flush
);

    logic          ms_valid_q;
    logic          first_q;
    es_to_ms_bus_t bus_q;
    logic [31:0]   hold_q;

    logic          ms_ready_go;
    logic          flush;
    logic [31:0]   align_data;
    logic [3:0]    align_wstrb;
    logic [31:0]   load_data;
    logic [31:0]   result;
    logic [3:0]    rf_wstrb;
    logic          partial_load;

    assign flush       = pipeline_flush.ex | pipeline_flush.eret;
    assign ms_ready_go = ms_valid_q;
    assign ms_allowin  = !ms_valid_q || (ms_ready_go && ws_allowin);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q <= 1'b0;
            first_q    <= 1'b0;
        end else if (flush) begin
            ms_valid_q <= 1'b0;
            first_q    <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_q <= es_to_ms_bus.valid;
            first_q    <= es_to_ms_bus.valid;
        end else begin
            first_q    <= 1'b0;
        end
    end

    // NOTE: data registers are not reset; they are qualified by ms_valid_q.
    always_ff @(posedge clk) begin
        if (es_to_ms_bus.valid && ms_allowin) begin
            bus_q <= es_to_ms_bus;
        end
        // SRAM data is only valid in the first cycle; keep it for a stall.
        if (first_q) begin
            hold_q <= align_data;
        end
    end

    load_align u_load_align (
        .load_op_i (bus_q.load_op),
        .a_i       (bus_q.final_result[1:0]),
        .r_i       (data_sram_rdata),
        .data_o    (align_data),
        .wstrb_o   (align_wstrb)
    );

    assign load_data    = first_q ? align_data : hold_q;
    assign result       = bus_q.res_from_mem ? load_data : bus_q.final_result;
    assign partial_load = bus_q.load_op[LOAD_LWL] | bus_q.load_op[LOAD_LWR];

    always_comb begin
        rf_wstrb = partial_load ? align_wstrb : {4{bus_q.rf_we}};
        if (!ms_valid_q || bus_q.exception.ex) begin
            rf_wstrb = 4'b0000;
        end
    end

    always_comb begin
        ms_to_ws_bus.valid     = ms_valid_q;
        ms_to_ws_bus.c0_op     = bus_q.c0_op;
        ms_to_ws_bus.c0_addr   = bus_q.c0_addr;
        ms_to_ws_bus.rf_wstrb  = rf_wstrb;
        ms_to_ws_bus.dest      = bus_q.dest;
        ms_to_ws_bus.result    = result;
        ms_to_ws_bus.pc        = bus_q.pc;
        ms_to_ws_bus.exception = bus_q.exception;
    end

    assign ms_forward_bus.op_mfc0  = bus_q.c0_op[C0_MFC0] & ms_valid_q;
    assign ms_forward_bus.dest     = bus_q.dest & {5{ms_valid_q}};
    assign ms_forward_bus.rf_wstrb = rf_wstrb;
    assign ms_forward_bus.result   = result;

    assign ms_wr_disable = ms_valid_q & (bus_q.exception.ex | bus_q.c0_op[C0_ERET]);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage using a table of directed
// load vectors plus hand-written stall, exception, flush and reset sequences.
module tb_mem_stage;
    import cpu_defs::*;

    logic            clk;
    logic            reset;
    logic            ws_allowin;
    logic            ms_allowin;
    es_to_ms_bus_t   es_to_ms_bus;
    logic [31:0]     data_sram_rdata;
    ms_to_ws_bus_t   ms_to_ws_bus;
    ms_forward_bus_t ms_forward_bus;
    logic            ms_wr_disable;
    pipeline_flush_t pipeline_flush;

    int checks;
    int failures;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_bus    (es_to_ms_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_forward_bus  (ms_forward_bus),
        .ms_wr_disable   (ms_wr_disable),
        .pipeline_flush  (pipeline_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [6:0]  load_op;
        logic        res_from_mem;
        logic        rf_we;
        logic [31:0] final_result;
        logic [31:0] rdata;
        logic [31:0] exp_result;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string n, input int lop_bit, input logic rfm,
                                input logic we, input logic [31:0] fr, input logic [31:0] rd,
                                input logic [31:0] er, input logic [3:0] ew);
        vec_t v;
        v.name = n;
        v.load_op = (lop_bit < 0) ? 7'b0 : (7'b1 << lop_bit);
        v.res_from_mem = rfm;
        v.rf_we = we;
        v.final_result = fr;
        v.rdata = rd;
        v.exp_result = er;
        v.exp_wstrb = ew;
        return v;
    endfunction

    task automatic drive(input logic [6:0] lop, input logic rfm, input logic we,
                         input logic [31:0] fr, input logic [4:0] dst, input logic [2:0] c0,
                         input logic exc);
        es_to_ms_bus = '0;
        es_to_ms_bus.valid = 1'b1;
        es_to_ms_bus.load_op = lop;
        es_to_ms_bus.res_from_mem = rfm;
        es_to_ms_bus.rf_we = we;
        es_to_ms_bus.final_result = fr;
        es_to_ms_bus.dest = dst;
        es_to_ms_bus.c0_op = c0;
        es_to_ms_bus.pc = 32'hBFC0_0100;
        es_to_ms_bus.exception.ex = exc;
        es_to_ms_bus.exception.excode = exc ? 5'h04 : 5'h00;
        es_to_ms_bus.exception.badvaddr = exc ? fr : 32'h0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(ms_to_ws_bus.valid), 32'd0);
        check({tag, "_wstrb"}, 32'(ms_to_ws_bus.rf_wstrb), 32'd0);
        check({tag, "_fwd_dest"}, 32'(ms_forward_bus.dest), 32'd0);
        check({tag, "_op_mfc0"}, 32'(ms_forward_bus.op_mfc0), 32'd0);
        check({tag, "_wr_dis"}, 32'(ms_wr_disable), 32'd0);
        check({tag, "_allowin"}, 32'(ms_allowin), 32'd1);
    endtask

    initial begin
        checks = 0;
        failures = 0;

        vecs[0]  = mk("lb_a3",    LOAD_LB,  1, 1, 32'h1000_0003, 32'h80FF_1234, 32'hFFFF_FF80, 4'b1111);
        vecs[1]  = mk("lbu_a3",   LOAD_LBU, 1, 1, 32'h1000_0003, 32'h80FF_1234, 32'h0000_0080, 4'b1111);
        vecs[2]  = mk("lwl_a1",   LOAD_LWL, 1, 1, 32'h1000_0001, 32'hAABB_CCDD, 32'hCCDD_0000, 4'b1100);
        vecs[3]  = mk("lwr_a2",   LOAD_LWR, 1, 1, 32'h1000_0002, 32'hAABB_CCDD, 32'h0000_AABB, 4'b0011);
        vecs[4]  = mk("lw_a0",    LOAD_LW,  1, 1, 32'h1000_0000, 32'h1234_5678, 32'h1234_5678, 4'b1111);
        vecs[5]  = mk("lh_a2",    LOAD_LH,  1, 1, 32'h1000_0002, 32'h8001_7FFF, 32'hFFFF_8001, 4'b1111);
        vecs[6]  = mk("lhu_a0",   LOAD_LHU, 1, 1, 32'h1000_0000, 32'h8001_F0F0, 32'h0000_F0F0, 4'b1111);
        vecs[7]  = mk("lb_a1",    LOAD_LB,  1, 1, 32'h1000_0001, 32'h0000_7F00, 32'h0000_007F, 4'b1111);
        vecs[8]  = mk("alu",      -1,       0, 1, 32'hDEAD_BEEF, 32'h5555_5555, 32'hDEAD_BEEF, 4'b1111);
        vecs[9]  = mk("no_we",    -1,       0, 0, 32'h0000_0004, 32'h5555_5555, 32'h0000_0004, 4'b0000);
        vecs[10] = mk("lwl_a3",   LOAD_LWL, 1, 1, 32'h1000_0003, 32'hAABB_CCDD, 32'hAABB_CCDD, 4'b1111);
        vecs[11] = mk("lwl_a0",   LOAD_LWL, 1, 1, 32'h1000_0000, 32'hAABB_CCDD, 32'hDD00_0000, 4'b1000);
        vecs[12] = mk("lwr_a0",   LOAD_LWR, 1, 1, 32'h1000_0000, 32'hAABB_CCDD, 32'hAABB_CCDD, 4'b1111);
        vecs[13] = mk("lwr_a3",   LOAD_LWR, 1, 1, 32'h1000_0003, 32'hAABB_CCDD, 32'h0000_00AA, 4'b0001);

        reset = 1'b1;
        ws_allowin = 1'b1;
        es_to_ms_bus = '0;
        data_sram_rdata = 32'h0;
        pipeline_flush = '0;
        step();
        step();
        check_reset_state("reset");
        reset = 1'b0;

        // Table-driven vectors, one instruction per pass.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].load_op, vecs[i].res_from_mem, vecs[i].rf_we,
                  vecs[i].final_result, 5'(i + 1), 3'b000, 1'b0);
            step();
            es_to_ms_bus.valid = 1'b0;
            data_sram_rdata = vecs[i].rdata;
            #1;
            check({vecs[i].name, "_valid"}, 32'(ms_to_ws_bus.valid), 32'd1);
            check({vecs[i].name, "_result"}, ms_to_ws_bus.result, vecs[i].exp_result);
            check({vecs[i].name, "_wstrb"}, 32'(ms_to_ws_bus.rf_wstrb), 32'(vecs[i].exp_wstrb));
            check({vecs[i].name, "_fwd_res"}, ms_forward_bus.result, vecs[i].exp_result);
            check({vecs[i].name, "_fwd_dest"}, 32'(ms_forward_bus.dest), 32'(i + 1));
        end
        step();
        check("drain_valid", 32'(ms_to_ws_bus.valid), 32'd0);

        // Stall: ws_allowin low for 3 cycles, rdata garbage after first.
        ws_allowin = 1'b0;
        drive(7'b1 << LOAD_LB, 1, 1, 32'h1000_0003, 5'd7, 3'b000, 1'b0);
        step();
        es_to_ms_bus.valid = 1'b0;
        data_sram_rdata = 32'h80FF_1234;
        #1;
        check("stall_c0_result", ms_to_ws_bus.result, 32'hFFFF_FF80);
        check("stall_c0_allowin", 32'(ms_allowin), 32'd0);
        for (int c = 1; c < 3; c++) begin
            step();
            data_sram_rdata = 32'h1234_5678 + 32'(c);
            #1;
            check("stall_hold_result", ms_to_ws_bus.result, 32'hFFFF_FF80);
            check("stall_hold_allowin", 32'(ms_allowin), 32'd0);
            check("stall_hold_valid", 32'(ms_to_ws_bus.valid), 32'd1);
        end
        ws_allowin = 1'b1;
        #1;
        check("stall_release_result", ms_to_ws_bus.result, 32'hFFFF_FF80);
        check("stall_release_allowin", 32'(ms_allowin), 32'd1);
        step();
        check("stall_after_valid", 32'(ms_to_ws_bus.valid), 32'd0);

        // Back-to-back loads: no bubble.
        drive(7'b1 << LOAD_LBU, 1, 1, 32'h1000_0002, 5'd3, 3'b000, 1'b0);
        step();
        drive(7'b1 << LOAD_LHU, 1, 1, 32'h1000_0002, 5'd4, 3'b000, 1'b0);
        data_sram_rdata = 32'h00AB_0000;
        #1;
        check("b2b_first", ms_to_ws_bus.result, 32'h0000_00AB);
        step();
        es_to_ms_bus.valid = 1'b0;
        data_sram_rdata = 32'hC001_0000;
        #1;
        check("b2b_second_valid", 32'(ms_to_ws_bus.valid), 32'd1);
        check("b2b_second", ms_to_ws_bus.result, 32'h0000_C001);
        check("b2b_second_dest", 32'(ms_forward_bus.dest), 32'd4);

        // Exception carried in on LW (AdEL).
        drive(7'b1 << LOAD_LW, 1, 1, 32'h0000_1001, 5'd9, 3'b000, 1'b1);
        step();
        es_to_ms_bus.valid = 1'b0;
        #1;
        check("exc_wstrb", 32'(ms_to_ws_bus.rf_wstrb), 32'd0);
        check("exc_wr_dis", 32'(ms_wr_disable), 32'd1);
        check("exc_badvaddr", ms_to_ws_bus.exception.badvaddr, 32'h0000_1001);
        check("exc_ex", 32'(ms_to_ws_bus.exception.ex), 32'd1);
        step();
        check("exc_gone_wr_dis", 32'(ms_wr_disable), 32'd0);

        // ERET and MFC0 in the stage.
        drive(7'b0, 0, 0, 32'h0, 5'd0, 3'b001, 1'b0);
        step();
        drive(7'b0, 0, 1, 32'h0, 5'd12, 3'b100, 1'b0);
        #1;
        check("eret_wr_dis", 32'(ms_wr_disable), 32'd1);
        check("eret_op_mfc0", 32'(ms_forward_bus.op_mfc0), 32'd0);
        step();
        es_to_ms_bus.valid = 1'b0;
        #1;
        check("mfc0_op_mfc0", 32'(ms_forward_bus.op_mfc0), 32'd1);
        check("mfc0_wr_dis", 32'(ms_wr_disable), 32'd0);

        // Flush with a valid instruction held and a new one arriving.
        ws_allowin = 1'b0;
        step();
        drive(7'b1 << LOAD_LW, 1, 1, 32'h1000_0000, 5'd5, 3'b000, 1'b0);
        step();
        drive(7'b1 << LOAD_LW, 1, 1, 32'h1000_0004, 5'd6, 3'b000, 1'b0);
        ws_allowin = 1'b1;
        pipeline_flush.ex = 1'b1;
        #1;
        check("flush_pre_valid", 32'(ms_to_ws_bus.valid), 32'd1);
        step();
        pipeline_flush.ex = 1'b0;
        es_to_ms_bus.valid = 1'b0;
        #1;
        check("flush_valid", 32'(ms_to_ws_bus.valid), 32'd0);
        check("flush_fwd_dest", 32'(ms_forward_bus.dest), 32'd0);
        check("flush_wstrb", 32'(ms_to_ws_bus.rf_wstrb), 32'd0);

        // Reset mid-stream while an instruction is stalled in the stage.
        ws_allowin = 1'b0;
        drive(7'b0, 0, 1, 32'h0, 5'd8, 3'b101, 1'b1);
        step();
        es_to_ms_bus.valid = 1'b0;
        #1;
        check("midrst_pre_valid", 32'(ms_to_ws_bus.valid), 32'd1);
        reset = 1'b1;
        step();
        check_reset_state("midrst");
        reset = 1'b0;
        ws_allowin = 1'b1;
        drive(7'b1 << LOAD_LH, 1, 1, 32'h1000_0000, 5'd10, 3'b000, 1'b0);
        step();
        es_to_ms_bus.valid = 1'b0;
        data_sram_rdata = 32'h0000_9ABC;
        #1;
        check("postrst_result", ms_to_ws_bus.result, 32'hFFFF_9ABC);
        check("postrst_wstrb", 32'(ms_to_ws_bus.rf_wstrb), 32'hF);
        check("postrst_dest", 32'(ms_forward_bus.dest), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
